// File: rtl/miner_pkg.sv
// Shared types, header word map and byte-swap helper for the mining front end.
package miner_pkg;

  typedef enum logic [2:0] {LOAD, DRAIN, KICK, RUN, RESULT} hl_state_t;

  localparam int W_VERSION = 0;
  localparam int W_PREV    = 1;
  localparam int W_MERKLE  = 9;
  localparam int W_TIME    = 17;
  localparam int W_BITS    = 18;
  localparam int W_TARGET  = 19;
  localparam int HDR_WORDS = 20;
  localparam int IDX_W     = 5;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/header_loader.sv
// Loads a 20-word block header, runs multi_supervisor and holds its result.
// Build option: define BSWAP_IN_EN to byte-reverse every accepted header word.
module header_loader
  import miner_pkg::*;
#(
  parameter int CYC_W     = 48,
  parameter int TGT_RESET = 16
) (
  input  logic              clk,
  input  logic              reset,
  // Header stream: a word transfers on a rising edge where s_valid && s_ready.
  // s_ready does not depend on s_valid; s_valid/s_data/s_last hold until taken.
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  input  logic              abort,
  output logic              sup_reset,
  output logic              sup_start,
  output logic [31:0]       version,
  output logic [255:0]      hashPrevBlock,
  output logic [255:0]      hashMerkleRoot,
  output logic [31:0]       timestamp,
  output logic [31:0]       bits,
  output logic [31:0]       target_bits,
  input  logic              sup_done,
  input  logic [255:0]      sup_hash,
  input  logic [31:0]       sup_nonce,
  input  logic              sup_success,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [255:0]      res_hash,
  output logic [31:0]       res_nonce,
  output logic              res_success,
  output logic [CYC_W-1:0]  res_cycles,
  output logic              err_frame,
  output hl_state_t         dbg_state,
  output logic [IDX_W-1:0]  dbg_word_idx
);

  localparam logic [IDX_W-1:0] IDX_VERSION = IDX_W'(W_VERSION);
  localparam logic [IDX_W-1:0] IDX_MERKLE  = IDX_W'(W_MERKLE);
  localparam logic [IDX_W-1:0] IDX_TIME    = IDX_W'(W_TIME);
  localparam logic [IDX_W-1:0] IDX_BITS    = IDX_W'(W_BITS);
  localparam logic [IDX_W-1:0] IDX_TARGET  = IDX_W'(W_TARGET);

  hl_state_t          r_state;
  logic [IDX_W-1:0]   r_word_idx;
  logic [31:0]        r_version;
  logic [255:0]       r_prev;
  logic [255:0]       r_merkle;
  logic [31:0]        r_time;
  logic [31:0]        r_bits;
  logic [31:0]        r_target;
  logic               r_sup_reset;
  logic               r_sup_start;
  logic               r_res_valid;
  logic [255:0]       r_res_hash;
  logic [31:0]        r_res_nonce;
  logic               r_res_success;
  logic [CYC_W-1:0]   r_res_cycles;
  logic [CYC_W-1:0]   r_cnt;
  logic               r_err_frame;

  logic [31:0]        w_data;
  logic               w_accept;
  logic [2:0]         w_prev_slot;
  logic [2:0]         w_merkle_slot;

`ifdef BSWAP_IN_EN
  assign w_data = bswap32(s_data);
`else
  assign w_data = s_data;
`endif

  // Abort wins over a word offered in the same cycle, so the word is not taken.
  assign s_ready  = ((r_state == LOAD) || (r_state == DRAIN)) && !abort;
  assign w_accept = s_valid && s_ready;

  // First word of each 256-bit field lands in the top 32 bits (slot 7).
  assign w_prev_slot   = 3'(IDX_W'(W_MERKLE - 1) - r_word_idx);
  assign w_merkle_slot = 3'(IDX_W'(W_TIME - 1) - r_word_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= LOAD;
      r_word_idx    <= '0;
      r_version     <= '0;
      r_prev        <= '0;
      r_merkle      <= '0;
      r_time        <= '0;
      r_bits        <= '0;
      r_target      <= 32'(TGT_RESET);
      r_sup_reset   <= 1'b1;
      r_sup_start   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_hash    <= '0;
      r_res_nonce   <= '0;
      r_res_success <= 1'b0;
      r_res_cycles  <= '0;
      r_cnt         <= '0;
      r_err_frame   <= 1'b0;
    end else begin
      r_err_frame <= 1'b0;
      case (r_state)
        LOAD: begin
          if (abort) begin
            r_word_idx <= '0;
          end else if (w_accept) begin
            if (r_word_idx == IDX_VERSION)     r_version <= w_data;
            else if (r_word_idx < IDX_MERKLE)  r_prev[{w_prev_slot, 5'b0} +: 32] <= w_data;
            else if (r_word_idx < IDX_TIME)    r_merkle[{w_merkle_slot, 5'b0} +: 32] <= w_data;
            else if (r_word_idx == IDX_TIME)   r_time <= w_data;
            else if (r_word_idx == IDX_BITS)   r_bits <= w_data;
            else                               r_target <= w_data;

            if (r_word_idx == IDX_TARGET) begin
              r_word_idx <= '0;
              if (s_last) begin
                r_state <= KICK;
              end else begin
                r_err_frame <= 1'b1;
                r_state     <= DRAIN;
              end
            end else if (s_last) begin
              r_err_frame <= 1'b1;
              r_word_idx  <= '0;
            end else begin
              r_word_idx <= r_word_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (abort || (w_accept && s_last)) begin
            r_state    <= LOAD;
            r_word_idx <= '0;
          end
        end
        KICK: begin
          r_word_idx <= '0;
          if (abort) begin
            r_state <= LOAD;
          end else begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_sup_reset <= 1'b0;
            r_sup_start <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            r_state     <= LOAD;
            r_word_idx  <= '0;
            r_sup_reset <= 1'b1;
            r_sup_start <= 1'b0;
          end else if (sup_done) begin
            r_state       <= RESULT;
            r_res_valid   <= 1'b1;
            r_res_hash    <= sup_hash;
            r_res_nonce   <= sup_nonce;
            r_res_success <= sup_success;
            r_res_cycles  <= r_cnt;
            r_sup_reset   <= 1'b1;
            r_sup_start   <= 1'b0;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CYC_W'(1);
          end
        end
        RESULT: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= LOAD;
            r_word_idx  <= '0;
          end
        end
        default: begin
          r_state    <= LOAD;
          r_word_idx <= '0;
        end
      endcase
    end
  end

  assign sup_reset      = r_sup_reset;
  assign sup_start      = r_sup_start;
  assign version        = r_version;
  assign hashPrevBlock  = r_prev;
  assign hashMerkleRoot = r_merkle;
  assign timestamp      = r_time;
  assign bits           = r_bits;
  assign target_bits    = r_target;
  assign res_valid      = r_res_valid;
  assign res_hash       = r_res_hash;
  assign res_nonce      = r_res_nonce;
  assign res_success    = r_res_success;
  assign res_cycles     = r_res_cycles;
  assign err_frame      = r_err_frame;
  assign dbg_state      = r_state;
  assign dbg_word_idx   = r_word_idx;

endmodule

// File: tb/tb_header_loader.sv
// Randomized self-checking bench for header_loader; a second instance with a
// 4-bit cycle counter shares the stimulus to exercise counter saturation.
module tb_header_loader;
  import miner_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, s_valid, s_last, abort, sup_done, sup_success, res_ready;
  logic [31:0]  s_data, sup_nonce;
  logic [255:0] sup_hash;

  logic         s_ready, sup_reset, sup_start, res_valid, res_success, err_frame;
  logic [31:0]  version, timestamp, bits, target_bits, res_nonce;
  logic [255:0] hash_prev, merkle, res_hash;
  logic [47:0]  res_cycles;
  hl_state_t    dbg_state;
  logic [4:0]   dbg_word_idx;

  logic         b_s_ready, b_sup_reset, b_sup_start, b_res_valid, b_res_success, b_err_frame;
  logic [31:0]  b_version, b_timestamp, b_bits, b_target_bits, b_res_nonce;
  logic [255:0] b_hash_prev, b_merkle, b_res_hash;
  logic [3:0]   b_res_cycles;
  hl_state_t    b_dbg_state;
  logic [4:0]   b_dbg_word_idx;

  header_loader dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .abort(abort), .sup_reset(sup_reset), .sup_start(sup_start),
    .version(version), .hashPrevBlock(hash_prev), .hashMerkleRoot(merkle),
    .timestamp(timestamp), .bits(bits), .target_bits(target_bits),
    .sup_done(sup_done), .sup_hash(sup_hash), .sup_nonce(sup_nonce), .sup_success(sup_success),
    .res_valid(res_valid), .res_ready(res_ready), .res_hash(res_hash), .res_nonce(res_nonce),
    .res_success(res_success), .res_cycles(res_cycles), .err_frame(err_frame),
    .dbg_state(dbg_state), .dbg_word_idx(dbg_word_idx)
  );

  header_loader #(.CYC_W(4)) dut_sat (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .s_last(s_last), .abort(abort), .sup_reset(b_sup_reset), .sup_start(b_sup_start),
    .version(b_version), .hashPrevBlock(b_hash_prev), .hashMerkleRoot(b_merkle),
    .timestamp(b_timestamp), .bits(b_bits), .target_bits(b_target_bits),
    .sup_done(sup_done), .sup_hash(sup_hash), .sup_nonce(sup_nonce), .sup_success(sup_success),
    .res_valid(b_res_valid), .res_ready(res_ready), .res_hash(b_res_hash), .res_nonce(b_res_nonce),
    .res_success(b_res_success), .res_cycles(b_res_cycles), .err_frame(b_err_frame),
    .dbg_state(b_dbg_state), .dbg_word_idx(b_dbg_word_idx)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];     // {success, nonce} of each result the model expects
  logic [31:0] hdr[20];      // raw words as streamed

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected latched value of a streamed word.
  function automatic logic [31:0] mw(input logic [31:0] w);
    logic [31:0] r;
`ifdef BSWAP_IN_EN
    r = {<<8{w}};
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic check_fields();
    logic [255:0] ep, em;
    ep = '0;
    em = '0;
    for (int i = 1; i <= 8; i++)  ep = {ep[223:0], mw(hdr[i])};
    for (int i = 9; i <= 16; i++) em = {em[223:0], mw(hdr[i])};
    chk("version", version, mw(hdr[0]));
    chk("prev", hash_prev, ep);
    chk("merkle", merkle, em);
    chk("timestamp", timestamp, mw(hdr[17]));
    chk("bits", bits, mw(hdr[18]));
    chk("target", target_bits, mw(hdr[19]));
  endtask

  task automatic check_reset_state();
    chk("rst_state", dbg_state, LOAD);
    chk("rst_idx", dbg_word_idx, 0);
    chk("rst_sup_reset", sup_reset, 1);
    chk("rst_sup_start", sup_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_nonce", res_nonce, 0);
    chk("rst_res_cycles", res_cycles, 0);
    chk("rst_version", version, 0);
    chk("rst_prev", hash_prev, 0);
    chk("rst_target", target_bits, 16);
    chk("rst_err", err_frame, 0);
    chk("rst_ready", s_ready, 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_state();
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic load_header(input int max_gap);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_word(hdr[i], i == 19);
    end
    chk("kick_state", dbg_state, KICK);
    chk("kick_sup_reset", sup_reset, 1);
    chk("kick_sup_start", sup_start, 0);
    check_fields();
    @(negedge clk);
    chk("run_state", dbg_state, RUN);
    chk("run_sup_start", sup_start, 1);
    chk("run_sup_reset", sup_reset, 0);
    chk("run_ready", s_ready, 0);
  endtask

  // Entered at the first RUN cycle; the done level is raised after k RUN cycles.
  task automatic run_to_result(input int k, input logic [31:0] nonce, input logic succ, input int hold);
    logic [255:0] h;
    logic [32:0]  e;
    int           sat;
    for (int i = 0; i < 8; i++) h = {h[223:0], $urandom()};
    repeat (k) @(negedge clk);
    chk("pre_done_start", sup_start, 1);
    sup_hash    = h;
    sup_nonce   = nonce;
    sup_success = succ;
    sup_done    = 1'b1;
    exp_q.push_back({succ, nonce});
    @(negedge clk);
    e   = exp_q.pop_front();
    sat = (k > 15) ? 15 : k;
    chk("res_valid", res_valid, 1);
    chk("res_nonce", res_nonce, e[31:0]);
    chk("res_success", res_success, e[32]);
    chk("res_hash", res_hash, h);
    chk("res_cycles", res_cycles, k);
    chk("res_cycles_sat", b_res_cycles, sat);
    chk("res_sup_reset", sup_reset, 1);
    chk("res_sup_start", sup_start, 0);
    chk("res_state", dbg_state, RESULT);
    sup_nonce = $urandom();
    sup_hash  = ~h;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_nonce", res_nonce, e[31:0]);
      chk("hold_hash", res_hash, h);
      chk("hold_cycles", res_cycles, k);
      chk("hold_fields", version, mw(hdr[0]));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    sup_done  = 1'b0;
    chk("ack_valid", res_valid, 0);
    chk("ack_state", dbg_state, LOAD);
    chk("ack_idx", dbg_word_idx, 0);
    chk("ack_sup_reset", sup_reset, 1);
  endtask

  task automatic abort_in_run(input int k);
    repeat (k) @(negedge clk);
    abort    = 1'b1;
    sup_done = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    sup_done = 1'b0;
    chk("abort_state", dbg_state, LOAD);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_sup_start", sup_start, 0);
    chk("abort_sup_reset", sup_reset, 1);
    chk("abort_idx", dbg_word_idx, 0);
    @(negedge clk);
    chk("abort_res_valid2", res_valid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] p, m;
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; abort = 1'b0;
    sup_done = 1'b0; sup_success = 1'b0; sup_nonce = '0; sup_hash = '0; res_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Known block header
    p = 256'h00000000000008a3a41b85b8b29ad444def299fee21793cd8b9e567eab02cd81;
    m = 256'h2b12fcf1b09288fcaff797d71e950e71ae42b91e8bdb2304758dfcffc2b620e3;
    hdr[0] = 32'd1;
    for (int i = 0; i < 8; i++) begin
      hdr[1 + i] = p[255 - 32*i -: 32];
      hdr[9 + i] = m[255 - 32*i -: 32];
    end
    hdr[17] = 32'd1305998791;
    hdr[18] = 32'd440711666;
    hdr[19] = 32'd16;
    load_header(0);
    run_to_result(37, 32'd2504433986, 1'b1, 10);

    // Framing errors: early s_last, then a missing s_last
    for (int i = 0; i < 6; i++) send_word($urandom(), i == 5);
    chk("early_last_err", err_frame, 1);
    chk("early_last_state", dbg_state, LOAD);
    chk("early_last_idx", dbg_word_idx, 0);
    @(negedge clk);
    chk("early_last_pulse", err_frame, 0);
    for (int i = 0; i < 20; i++) begin
      send_word($urandom(), 1'b0);
      if (i == 18) chk("no_err_yet", err_frame, 0);
    end
    chk("missing_last_err", err_frame, 1);
    chk("missing_last_state", dbg_state, DRAIN);
    for (int i = 0; i < 3; i++) send_word($urandom(), 1'b0);
    chk("drain_state", dbg_state, DRAIN);
    chk("drain_err", err_frame, 0);
    send_word($urandom(), 1'b1);
    chk("drain_exit_state", dbg_state, LOAD);
    chk("drain_exit_idx", dbg_word_idx, 0);

    // Abort in RUN beats a simultaneous done
    load_header(1);
    abort_in_run(3);

    // Reset while a result is pending discards it
    load_header(0);
    run_to_result(20, 32'hdeadbeef, 1'b0, 2);
    load_header(0);
    sup_done = 1'b1;
    @(negedge clk);
    chk("pending_valid", res_valid, 1);
    sup_done = 1'b0;
    do_reset();

    // Randomized headers and runs
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 20; i++) hdr[i] = $urandom();
      if (it == 0) hdr[0] = 32'h01000000;
      load_header(2);
      if ($urandom_range(0, 3) == 0) abort_in_run($urandom_range(0, 10));
      else run_to_result($urandom_range(0, 40), $urandom(), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 4));
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
